axi_ctrl_dispatch: RTL and testbench

- Parametrised successor to the single LS/SS control path: buffers requests from NUM_CH backend channels in per-channel FIFOs.
- Arbitrates round-robin, decodes each address into mailbox (MB), AA-register, unsupported or forward targets, and runs one transaction at a time on a shared target port with a start/done handshake.
- Returns one tagged response per request.
- Sits between the axilite/axis backend slaves and the MB/AA register file plus the LM/SM forward path.

---
 rtl/axi_ctrl_dispatch.sv | 217 +++++++++++++++++++++
 tb/tb_axi_ctrl_dispatch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ctrl_dispatch.sv
// Per-channel request FIFOs, round-robin grant, and one shared-target transaction at a time.
// Optional WAIT timeout: define AXI_CTRL_DISPATCH_TIMEOUT_EN.
module axi_ctrl_dispatch #(
  parameter int                NUM_CH      = 2,
  parameter int                ADDR_W      = 15,
  parameter int                DATA_W      = 32,
  parameter int                FIFO_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] MB_LOW      = 15'h2000,
  parameter logic [ADDR_W-1:0] MB_HIGH     = 15'h201F,
  parameter logic [ADDR_W-1:0] AA_LOW      = 15'h2100,
  parameter logic [ADDR_W-1:0] AA_HIGH     = 15'h2107,
  parameter logic [ADDR_W-1:0] UNSUPP_HIGH = 15'h2FFF,
  parameter int                TIMEOUT_CYC = 256,
  localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int               SW          = DATA_W / 8
) (
  input  logic                     axi_aclk,
  input  logic                     axi_areset,
  input  logic [NUM_CH-1:0]        ch_req_vld,
  output logic [NUM_CH-1:0]        ch_req_rdy,
  input  logic [NUM_CH-1:0]        ch_req_wr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_req_wdata,
  input  logic [NUM_CH*SW-1:0]     ch_req_wstrb,
  output logic                     dst_start,
  output logic [1:0]               dst_sel,
  output logic                     dst_wr,
  output logic [ADDR_W-1:0]        dst_addr,
  output logic [DATA_W-1:0]        dst_wdata,
  output logic [SW-1:0]            dst_wstrb,
  input  logic                     dst_done,
  input  logic [DATA_W-1:0]        dst_rdata,
  output logic                     rsp_vld,
  output logic [CH_W-1:0]          rsp_ch,
  output logic                     rsp_wr,
  output logic                     rsp_err,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     axi_interrupt,
  input  logic                     irq_clr
);

  localparam int             PTR_W    = $clog2(FIFO_DEPTH);
  localparam int             ENT_W    = 1 + ADDR_W + DATA_W + SW;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_ch
    $error("NUM_CH must be 1..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_chk_tmo
    $error("TIMEOUT_CYC must be >= 1");
  end

  // state | meaning
  // IDLE  | pick next non-empty channel round-robin, pop it
  // ISSUE | decode latched address, pulse dst_start (or flag unsupported)
  // WAIT  | hold dst_* until dst_done (or timeout)
  // RESP  | one-cycle rsp_vld with latched channel/err/rdata
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [NUM_CH-1:0] push, pop, nonempty, rdy;
  logic [ENT_W-1:0]  head [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wp, rp;
    logic [PTR_W:0]   cnt, cnt_nxt;
    logic             rdy_q;

    assign push[g]     = ch_req_vld[g] & rdy_q;
    assign rdy[g]      = rdy_q;
    assign nonempty[g] = (cnt != '0);
    assign head[g]     = mem[rp];
    assign cnt_nxt     = cnt + (PTR_W+1)'(push[g]) - (PTR_W+1)'(pop[g]);

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
        wp    <= '0;
        rp    <= '0;
        cnt   <= '0;
        rdy_q <= 1'b0;
      end else begin
        if (push[g]) wp <= wp + PTR_W'(1);
        if (pop[g])  rp <= rp + PTR_W'(1);
        cnt   <= cnt_nxt;
        rdy_q <= (cnt_nxt != FULL_CNT);
      end
    end

    always_ff @(posedge axi_aclk) begin
      if (push[g])
        mem[wp] <= {ch_req_wr[g], ch_req_addr[g*ADDR_W +: ADDR_W],
                    ch_req_wdata[g*DATA_W +: DATA_W], ch_req_wstrb[g*SW +: SW]};
    end
  end

  logic [CH_W-1:0]   rr_ptr, rr_nxt, gnt, cur_ch;
  logic              found;
  logic              cur_wr, err_q, irq_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata, rdata_q;
  logic [SW-1:0]     cur_wstrb;
  logic [ENT_W-1:0]  hd;

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && nonempty[(int'(rr_ptr) + k) % NUM_CH]) begin
        found = 1'b1;
        gnt   = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
  end

  assign rr_nxt = CH_W'((int'(gnt) + 1) % NUM_CH);
  assign hd     = head[gnt];

  always_comb begin
    pop = '0;
    if (state == IDLE && found) pop[gnt] = 1'b1;
  end

  logic       in_mb, in_aa, unsupp;
  logic [1:0] sel;
  assign in_mb  = (cur_addr >= MB_LOW) && (cur_addr <= MB_HIGH);
  assign in_aa  = (cur_addr >= AA_LOW) && (cur_addr <= AA_HIGH);
  assign unsupp = (cur_addr >= MB_LOW) && (cur_addr <= UNSUPP_HIGH) && !in_mb && !in_aa;
  assign sel    = in_mb ? 2'd0 : (in_aa ? 2'd1 : 2'd2);

`ifdef AXI_CTRL_DISPATCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  // Firing on the last count means RESP lands exactly TIMEOUT_CYC cycles after WAIT entry.
  assign tmo_hit = (state == WAIT) && !dst_done && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset)           tmo_cnt <= '0;
    else if (state == ISSUE)  tmo_cnt <= '0;
    else if (state == WAIT)   tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    dst_start = 1'b0;
    case (state)
      IDLE:  if (found) state_nxt = ISSUE;
      ISSUE: begin
        if (unsupp) state_nxt = RESP;
        else begin
          dst_start = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT:  if (dst_done || tmo_hit) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_ch    <= '0;
      cur_wr    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_wstrb <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        {cur_wr, cur_addr, cur_wdata, cur_wstrb} <= hd;
        cur_ch  <= gnt;
        rr_ptr  <= rr_nxt;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
      if (state == ISSUE && unsupp) err_q <= 1'b1;
      if (state == WAIT) begin
        if (dst_done)     rdata_q <= cur_wr ? '0 : dst_rdata;
        else if (tmo_hit) err_q   <= 1'b1;
      end
      if ((state == ISSUE && unsupp) || tmo_hit) irq_q <= 1'b1;
      else if (irq_clr)                           irq_q <= 1'b0;
    end
  end

  logic drive, resp;
  assign drive = ((state == ISSUE) || (state == WAIT)) && !unsupp;
  assign resp  = (state == RESP);

  assign ch_req_rdy    = rdy;
  assign dst_sel       = drive ? sel : 2'd0;
  assign dst_wr        = drive & cur_wr;
  assign dst_addr      = drive ? cur_addr : '0;
  assign dst_wdata     = drive ? cur_wdata : '0;
  assign dst_wstrb     = drive ? cur_wstrb : '0;
  assign rsp_vld       = resp;
  assign rsp_ch        = resp ? cur_ch : '0;
  assign rsp_wr        = resp & cur_wr;
  assign rsp_err       = resp & err_q;
  assign rsp_rdata     = resp ? rdata_q : '0;
  assign axi_interrupt = irq_q;

endmodule

// File: tb/tb_axi_ctrl_dispatch.sv
// Directed, table-driven bench for axi_ctrl_dispatch, plus round-robin, FIFO-full,
// reset-abort and (with AXI_CTRL_DISPATCH_TIMEOUT_EN) timeout sequences.
module tb_axi_ctrl_dispatch;
  localparam int NUM_CH = 2, ADDR_W = 15, DATA_W = 32, SW = 4, CH_W = 1;

  logic                     axi_aclk = 1'b0;
  logic                     axi_areset = 1'b1;
  logic [NUM_CH-1:0]        ch_req_vld = '0, ch_req_rdy, ch_req_wr = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_req_addr = '0;
  logic [NUM_CH*DATA_W-1:0] ch_req_wdata = '0;
  logic [NUM_CH*SW-1:0]     ch_req_wstrb = '0;
  logic                     dst_start, dst_wr, dst_done = 1'b0;
  logic [1:0]               dst_sel;
  logic [ADDR_W-1:0]        dst_addr;
  logic [DATA_W-1:0]        dst_wdata, dst_rdata = '0, rsp_rdata;
  logic [SW-1:0]            dst_wstrb;
  logic                     rsp_vld, rsp_wr, rsp_err, axi_interrupt, irq_clr = 1'b0;
  logic [CH_W-1:0]          rsp_ch;

  always #5 axi_aclk = ~axi_aclk;

  axi_ctrl_dispatch #(.NUM_CH(NUM_CH), .TIMEOUT_CYC(16)) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .ch_req_vld(ch_req_vld), .ch_req_rdy(ch_req_rdy), .ch_req_wr(ch_req_wr),
    .ch_req_addr(ch_req_addr), .ch_req_wdata(ch_req_wdata), .ch_req_wstrb(ch_req_wstrb),
    .dst_start(dst_start), .dst_sel(dst_sel), .dst_wr(dst_wr), .dst_addr(dst_addr),
    .dst_wdata(dst_wdata), .dst_wstrb(dst_wstrb), .dst_done(dst_done), .dst_rdata(dst_rdata),
    .rsp_vld(rsp_vld), .rsp_ch(rsp_ch), .rsp_wr(rsp_wr), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .axi_interrupt(axi_interrupt), .irq_clr(irq_clr)
  );

  typedef struct {
    int          ch;
    logic        wr;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] drd;
    logic        err;
    logic [1:0]  sel;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vt[12];

  int n_checks = 0, n_errors = 0, cyc_no = 0;
  logic hold_done = 1'b0, done_pending = 1'b0, auto_rd = 1'b0;
  logic [31:0] vec_rd = '0;
  logic [31:0] st_addr_q[$], st_sel_q[$], st_wd_q[$];
  logic [31:0] rsp_ch_q[$], rsp_wr_q[$], rsp_err_q[$], rsp_rd_q[$], rsp_irq_q[$];
  int          rsp_t_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc_no);
    end
  endtask

  task automatic clear_q();
    st_addr_q.delete(); st_sel_q.delete(); st_wd_q.delete();
    rsp_ch_q.delete(); rsp_wr_q.delete(); rsp_err_q.delete();
    rsp_rd_q.delete(); rsp_irq_q.delete(); rsp_t_q.delete();
  endtask

  // One clock; acts as the target (done the cycle after start) and logs responses.
  task automatic step();
    @(posedge axi_aclk); #1;
    cyc_no++;
    dst_done = done_pending && !hold_done;
    if (dst_done) done_pending = 1'b0;
    if (dst_start) begin
      st_addr_q.push_back(32'(dst_addr));
      st_sel_q.push_back(32'(dst_sel));
      st_wd_q.push_back(dst_wdata);
      dst_rdata = auto_rd ? 32'h100 + 32'(st_addr_q.size() - 1) : vec_rd;
      done_pending = 1'b1;
    end
    if (rsp_vld) begin
      rsp_t_q.push_back(cyc_no);
      rsp_ch_q.push_back(32'(rsp_ch));
      rsp_wr_q.push_back(32'(rsp_wr));
      rsp_err_q.push_back(32'(rsp_err));
      rsp_rd_q.push_back(rsp_rdata);
      rsp_irq_q.push_back(32'(axi_interrupt));
    end
  endtask

  task automatic drive_req(input int ch, input logic wr, input logic [14:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    ch_req_vld[ch] = 1'b1;
    ch_req_wr[ch]  = wr;
    ch_req_addr[ch*ADDR_W +: ADDR_W]  = a;
    ch_req_wdata[ch*DATA_W +: DATA_W] = d;
    ch_req_wstrb[ch*SW +: SW]         = s;
  endtask

  task automatic do_reset();
    axi_areset = 1'b1;
    ch_req_vld = '0; dst_done = 1'b0; irq_clr = 1'b0;
    done_pending = 1'b0; hold_done = 1'b0;
    repeat (2) @(posedge axi_aclk);
    #1 axi_areset = 1'b0;
    step();
    clear_q();
  endtask

  initial begin
    int t0, k, bad, rsp_at_10th;
    vt[0]  = '{0, 1'b1, 15'h2004, 32'hA5A5_0001, 4'hF, 32'hDEAD_BEEF, 1'b0, 2'd0, 32'h0};
    vt[1]  = '{1, 1'b0, 15'h2103, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0, 2'd1, 32'h1234_5678};
    vt[2]  = '{0, 1'b0, 15'h2500, 32'h0000_0000, 4'h0, 32'h7777_7777, 1'b1, 2'd0, 32'h0};
    vt[3]  = '{1, 1'b1, 15'h0010, 32'h0000_BEEF, 4'h3, 32'h1111_1111, 1'b0, 2'd2, 32'h0};
    vt[4]  = '{0, 1'b0, 15'h201F, 32'h0000_0004, 4'h0, 32'hCAFE_0001, 1'b0, 2'd0, 32'hCAFE_0001};
    vt[5]  = '{1, 1'b0, 15'h2020, 32'h0000_0005, 4'h0, 32'h5555_5555, 1'b1, 2'd0, 32'h0};
    vt[6]  = '{0, 1'b0, 15'h2107, 32'h0000_0006, 4'h0, 32'h0000_AA07, 1'b0, 2'd1, 32'h0000_AA07};
    vt[7]  = '{1, 1'b0, 15'h2108, 32'h0000_0007, 4'h0, 32'h6666_6666, 1'b1, 2'd0, 32'h0};
    vt[8]  = '{0, 1'b1, 15'h2FFF, 32'h0000_0008, 4'hF, 32'h8888_8888, 1'b1, 2'd0, 32'h0};
    vt[9]  = '{1, 1'b0, 15'h3000, 32'h0000_0009, 4'h0, 32'h0BAD_F00D, 1'b0, 2'd2, 32'h0BAD_F00D};
    vt[10] = '{0, 1'b0, 15'h1FFF, 32'h0000_000A, 4'h0, 32'h1FFF_1FFF, 1'b0, 2'd2, 32'h1FFF_1FFF};
    vt[11] = '{1, 1'b0, 15'h2000, 32'h0000_000B, 4'h0, 32'h2000_2000, 1'b0, 2'd0, 32'h2000_2000};

    repeat (2) @(posedge axi_aclk);
    #1;
    chk("reset_rdy", 32'(ch_req_rdy), 32'h0);
    chk("reset_outs", 32'(|{dst_start, dst_sel, dst_wr, dst_addr, dst_wdata, dst_wstrb, rsp_vld,
                            rsp_ch, rsp_wr, rsp_err, rsp_rdata, axi_interrupt}), 32'h0);
    axi_areset = 1'b0;
    step();
    clear_q();
    chk("rdy_after_reset", 32'(ch_req_rdy), 32'h3);

    for (int i = 0; i < 12; i++) begin
      clear_q();
      auto_rd = 1'b0;
      vec_rd  = vt[i].drd;
      t0 = cyc_no;
      drive_req(vt[i].ch, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].wstrb);
      step();
      ch_req_vld = '0;
      for (int n = 0; n < 20 && rsp_ch_q.size() == 0; n++) step();
      chk($sformatf("v%0d_rsp_seen", i), 32'(rsp_ch_q.size()), 32'd1);
      chk($sformatf("v%0d_starts", i), 32'(st_addr_q.size()), vt[i].err ? 32'd0 : 32'd1);
      if (st_addr_q.size() > 0) begin
        chk($sformatf("v%0d_sel", i), st_sel_q[0], 32'(vt[i].sel));
        chk($sformatf("v%0d_addr", i), st_addr_q[0], 32'(vt[i].addr));
        chk($sformatf("v%0d_wdata", i), st_wd_q[0], vt[i].wdata);
      end
      if (rsp_ch_q.size() > 0) begin
        chk($sformatf("v%0d_latency", i), 32'(rsp_t_q[0] - t0), vt[i].err ? 32'd3 : 32'd4);
        chk($sformatf("v%0d_rsp_ch", i), rsp_ch_q[0], 32'(vt[i].ch));
        chk($sformatf("v%0d_rsp_wr", i), rsp_wr_q[0], 32'(vt[i].wr));
        chk($sformatf("v%0d_rsp_err", i), rsp_err_q[0], 32'(vt[i].err));
        chk($sformatf("v%0d_rsp_rdata", i), rsp_rd_q[0], vt[i].exp_rd);
        chk($sformatf("v%0d_irq", i), rsp_irq_q[0], 32'(vt[i].err));
      end
      step();
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      chk($sformatf("v%0d_irq_cleared", i), 32'(axi_interrupt), 32'h0);
    end

    // Round-robin: both channels queue three forward reads in the same cycles.
    do_reset();
    auto_rd = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive_req(0, 1'b0, 15'h0010, 32'h0, 4'h0);
      drive_req(1, 1'b0, 15'h0010, 32'h0, 4'h0);
      step();
    end
    ch_req_vld = '0;
    for (int n = 0; n < 60 && rsp_ch_q.size() < 6; n++) step();
    chk("rr_rsp_count", 32'(rsp_ch_q.size()), 32'd6);
    for (int i = 0; i < rsp_ch_q.size(); i++) begin
      chk($sformatf("rr_ch_%0d", i), rsp_ch_q[i], 32'(i % 2));
      chk($sformatf("rr_rdata_%0d", i), rsp_rd_q[i], 32'h100 + 32'(i));
      chk($sformatf("rr_sel_%0d", i), st_sel_q[i], 32'd2);
      if (i > 0) chk($sformatf("rr_spacing_%0d", i), 32'(rsp_t_q[i] - rsp_t_q[i-1]), 32'd4);
    end

    // FIFO full: ten pushes on channel 0 while the target stalls the first transaction.
    do_reset();
    auto_rd = 1'b1;
    hold_done = 1'b1;
    k = 0;
    for (int n = 0; n < 12; n++) begin
      logic acc;
      drive_req(0, 1'b0, 15'h0100 + 15'(k), 32'(k), 4'h0);
      acc = ch_req_vld[0] && ch_req_rdy[0];
      step();
      if (acc) k++;
    end
    chk("full_accepted", 32'(k), 32'd9);
    chk("full_rdy_low", 32'(ch_req_rdy[0]), 32'd0);
    chk("full_no_rsp", 32'(rsp_ch_q.size()), 32'd0);
    hold_done = 1'b0;
    rsp_at_10th = -1;
    for (int n = 0; n < 20 && k < 10; n++) begin
      logic acc;
      drive_req(0, 1'b0, 15'h0100 + 15'(k), 32'(k), 4'h0);
      acc = ch_req_vld[0] && ch_req_rdy[0];
      step();
      if (acc) begin
        k++;
        rsp_at_10th = rsp_ch_q.size();
      end
    end
    ch_req_vld = '0;
    chk("full_10th_accepted", 32'(k), 32'd10);
    chk("full_10th_after_pop", 32'(rsp_at_10th), 32'd1);
    for (int n = 0; n < 150 && rsp_ch_q.size() < 10; n++) step();
    chk("full_rsp_count", 32'(rsp_ch_q.size()), 32'd10);
    bad = 0;
    for (int i = 0; i < st_addr_q.size(); i++)
      if (st_addr_q[i] != 32'h100 + 32'(i)) bad++;
    chk("full_fifo_order", 32'(bad), 32'd0);

    // Reset in the middle of a transaction drops everything without a response.
    do_reset();
    hold_done = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive_req(1, 1'b0, 15'h0200, 32'h0, 4'h0);
      step();
    end
    ch_req_vld = '0;
    step();
    chk("abort_started", 32'(st_addr_q.size()), 32'd1);
    axi_areset = 1'b1;
    #1;
    chk("abort_outs", 32'(|{ch_req_rdy, dst_start, dst_addr, rsp_vld, rsp_err}), 32'h0);
    @(posedge axi_aclk);
    #1 axi_areset = 1'b0;
    hold_done = 1'b0; done_pending = 1'b0;
    clear_q();
    repeat (15) step();
    chk("abort_no_start", 32'(st_addr_q.size()), 32'd0);
    chk("abort_no_rsp", 32'(rsp_ch_q.size()), 32'd0);
    chk("abort_rdy", 32'(ch_req_rdy), 32'h3);

`ifdef AXI_CTRL_DISPATCH_TIMEOUT_EN
    do_reset();
    auto_rd = 1'b0;
    vec_rd = 32'h5555_AAAA;
    hold_done = 1'b1;
    t0 = cyc_no;
    drive_req(0, 1'b0, 15'h0040, 32'h0, 4'h0);
    step();
    ch_req_vld = '0;
    for (int n = 0; n < 40 && rsp_ch_q.size() == 0; n++) step();
    chk("tmo_rsp_seen", 32'(rsp_ch_q.size()), 32'd1);
    if (rsp_ch_q.size() > 0) begin
      chk("tmo_latency", 32'(rsp_t_q[0] - t0), 32'd19);
      chk("tmo_err", rsp_err_q[0], 32'd1);
      chk("tmo_rdata", rsp_rd_q[0], 32'h0);
      chk("tmo_irq", rsp_irq_q[0], 32'd1);
    end
    hold_done = 1'b0;
    repeat (10) step();
    chk("tmo_late_done_ignored", 32'(rsp_ch_q.size()), 32'd1);
    chk("tmo_single_start", 32'(st_addr_q.size()), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
